// File: rtl/gbc_memory_bus.sv
// Game Boy Color CPU-side memory bus: decodes pipelined Wishbone requests, serves
// HRAM and the VBK/SVBK bank registers locally, forwards the rest to WRAM/VRAM/cart.
module gbc_memory_bus #(
  parameter logic [15:0] HRAM_BASE = 16'hFF80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [15:0] s_addr,
  input  logic [7:0]  s_dat_i,
  output logic [7:0]  s_dat_o,
  output logic        s_ack,
  output logic        s_stall,
  output logic        wram_cyc,
  output logic        wram_stb,
  output logic        wram_we,
  output logic [14:0] wram_addr,
  output logic [7:0]  wram_dat_o,
  input  logic [7:0]  wram_dat_i,
  input  logic        wram_ack,
  input  logic        wram_stall,
  output logic        vram_cyc,
  output logic        vram_stb,
  output logic        vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_dat_o,
  input  logic [7:0]  vram_dat_i,
  input  logic        vram_ack,
  input  logic        vram_stall,
  output logic        cart_cyc,
  output logic        cart_stb,
  output logic        cart_we,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_dat_o,
  input  logic [7:0]  cart_dat_i,
  input  logic        cart_ack,
  input  logic        cart_stall
);

  localparam int unsigned HRAM_AW    = 7;
  localparam int unsigned HRAM_DEPTH = 128;
  localparam int unsigned NTGT       = 3;   // one-hot target select {cart, vram, wram}

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [NTGT-1:0]       cyc_q, cyc_d, stb_q, stb_d, sel_q, sel_d;
  logic [15:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [7:0]            wdat_q, wdat_d;
  logic [7:0]            rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  stall_q, stall_d;
  logic                  vbk_q, vbk_d;
  logic [2:0]            svbk_q, svbk_d;
  logic [7:0]            hram [HRAM_DEPTH];
  logic                  hram_we;

  logic [NTGT-1:0]       dec_sel;
  logic [15:0]           dec_addr;
  logic [7:0]            loc_rdata;
  logic                  hit_hram, hit_vbk, hit_svbk;
  logic [2:0]            wbank;
  logic [HRAM_AW-1:0]    hram_idx;
  logic                  accept, tgt_ack, tgt_stall;
  logic [7:0]            tgt_dat;

  assign hram_idx = HRAM_AW'(s_addr - HRAM_BASE);
  assign wbank    = (svbk_q == 3'd0) ? 3'd1 : svbk_q;

  // Address decode and translation for the request currently on the bus
  always_comb begin
    dec_sel   = '0;
    dec_addr  = s_addr;
    loc_rdata = 8'hFF;
    hit_hram  = 1'b0;
    hit_vbk   = 1'b0;
    hit_svbk  = 1'b0;
    if (!s_addr[15] || s_addr[15:13] == 3'b101) begin
      dec_sel = 3'b100;
    end else if (s_addr[15:13] == 3'b100) begin
      dec_sel  = 3'b010;
      dec_addr = {2'b00, vbk_q, s_addr[12:0]};
    end else if (s_addr[15:12] == 4'hC || s_addr[15:12] == 4'hE) begin
      dec_sel  = 3'b001;
      dec_addr = {4'h0, s_addr[11:0]};
    end else if (s_addr[15:12] == 4'hD || (s_addr[15:12] == 4'hF && s_addr[11:9] != 3'b111)) begin
      dec_sel  = 3'b001;
      dec_addr = {1'b0, wbank, s_addr[11:0]};
    end else if (s_addr >= HRAM_BASE) begin
      hit_hram  = 1'b1;
      loc_rdata = hram[hram_idx];
    end else if (s_addr == 16'hFF4F) begin
      hit_vbk   = 1'b1;
      loc_rdata = {7'h7F, vbk_q};
    end else if (s_addr == 16'hFF70) begin
      hit_svbk  = 1'b1;
      loc_rdata = {5'h1F, svbk_q};
    end
  end

  assign accept    = s_cyc & s_stb & ((state_q == ST_IDLE) | (state_q == ST_RESP));
  assign tgt_ack   = |(sel_q & {cart_ack, vram_ack, wram_ack});
  assign tgt_stall = |(sel_q & {cart_stall, vram_stall, wram_stall});
  assign tgt_dat   = sel_q[2] ? cart_dat_i : (sel_q[1] ? vram_dat_i : wram_dat_i);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    stall_d = stall_q;
    vbk_d   = vbk_q;
    svbk_d  = svbk_q;
    hram_we = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
        if (accept) begin
          if (dec_sel != '0) begin
            state_d = ST_REQ;
            cyc_d   = dec_sel;
            stb_d   = dec_sel;
            sel_d   = dec_sel;
            addr_d  = dec_addr;
            we_d    = s_we;
            wdat_d  = s_dat_i;
            stall_d = 1'b1;
          end else begin
            ack_d  = 1'b1;
            rdat_d = loc_rdata;
            if (s_we) begin
              hram_we = hit_hram;
              if (hit_vbk)  vbk_d  = s_dat_i[0];
              if (hit_svbk) svbk_d = s_dat_i[2:0];
            end
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        if (!s_cyc) begin
          // CPU abandoned the cycle: release the target, any late ack is ignored
          state_d = ST_IDLE;
          cyc_d   = '0;
          stb_d   = '0;
          stall_d = 1'b0;
        end else if (state_q == ST_WAIT || !tgt_stall) begin
          stb_d = '0;
          if (state_q == ST_REQ) state_d = ST_WAIT;
          if (tgt_ack) begin
            state_d = ST_RESP;
            cyc_d   = '0;
            ack_d   = 1'b1;
            rdat_d  = tgt_dat;
            stall_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      stb_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= 8'hFF;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      vbk_q   <= 1'b0;
      svbk_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
      vbk_q   <= vbk_d;
      svbk_q  <= svbk_d;
    end
  end

  // HRAM contents survive reset
  always_ff @(posedge clk) begin
    if (hram_we) hram[hram_idx] <= s_dat_i;
  end

  assign s_dat_o    = rdat_q;
  assign s_ack      = ack_q;
  assign s_stall    = stall_q;
  assign wram_cyc   = cyc_q[0];
  assign wram_stb   = stb_q[0];
  assign wram_we    = we_q;
  assign wram_addr  = addr_q[14:0];
  assign wram_dat_o = wdat_q;
  assign vram_cyc   = cyc_q[1];
  assign vram_stb   = stb_q[1];
  assign vram_we    = we_q;
  assign vram_addr  = addr_q[13:0];
  assign vram_dat_o = wdat_q;
  assign cart_cyc   = cyc_q[2];
  assign cart_stb   = stb_q[2];
  assign cart_we    = we_q;
  assign cart_addr  = addr_q;
  assign cart_dat_o = wdat_q;

endmodule

// File: tb/tb_gbc_memory_bus.sv
// Scoreboard bench for gbc_memory_bus: directed local and forwarded accesses,
// a programmable target responder, and an ack monitor popping expected responses.
`timescale 1ns/1ps
module tb_gbc_memory_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [15:0] s_addr = '0;
  logic [7:0]  s_dat_i = '0;
  logic [7:0]  s_dat_o;
  logic        s_ack, s_stall;
  logic        wram_cyc, wram_stb, wram_we, vram_cyc, vram_stb, vram_we, cart_cyc, cart_stb, cart_we;
  logic [14:0] wram_addr;
  logic [13:0] vram_addr;
  logic [15:0] cart_addr;
  logic [7:0]  wram_dat_o, vram_dat_o, cart_dat_o;
  logic        wram_ack, wram_stall, vram_ack, vram_stall, cart_ack, cart_stall;

  // responder configuration and log of the last request it saw
  logic        t_stall = 1'b0, t_ack = 1'b0;
  int          stall_cfg = 0, cnt = 0;
  logic        ack_same = 1'b0;
  logic [7:0]  rdata = '0;
  logic [2:0]  log_sel = '0;
  logic [15:0] log_addr = '0;
  logic        log_we = 1'b0;
  logic [7:0]  log_dat = '0;
  logic        hold_viol = 1'b0;
  typedef enum int {T_IDLE, T_STALL, T_ACK} tstate_t;
  tstate_t     tst = T_IDLE;

  assign wram_stall = t_stall;
  assign vram_stall = t_stall;
  assign cart_stall = t_stall;
  assign wram_ack   = t_ack & log_sel[0];
  assign vram_ack   = t_ack & log_sel[1];
  assign cart_ack   = t_ack & log_sel[2];

  gbc_memory_bus dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack(s_ack), .s_stall(s_stall),
    .wram_cyc(wram_cyc), .wram_stb(wram_stb), .wram_we(wram_we), .wram_addr(wram_addr),
    .wram_dat_o(wram_dat_o), .wram_dat_i(rdata), .wram_ack(wram_ack), .wram_stall(wram_stall),
    .vram_cyc(vram_cyc), .vram_stb(vram_stb), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_dat_o(vram_dat_o), .vram_dat_i(rdata), .vram_ack(vram_ack), .vram_stall(vram_stall),
    .cart_cyc(cart_cyc), .cart_stb(cart_stb), .cart_we(cart_we), .cart_addr(cart_addr),
    .cart_dat_o(cart_dat_o), .cart_dat_i(rdata), .cart_ack(cart_ack), .cart_stall(cart_stall)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  wire any_stb = wram_stb | vram_stb | cart_stb;
  wire any_cyc = wram_cyc | vram_cyc | cart_cyc;

  // Target model: optional stall count, then ack (same cycle as acceptance or one later)
  always @(posedge clk) begin
    #1;
    t_ack = 1'b0;
    case (tst)
      T_IDLE: if (any_stb) begin
        log_sel  = {cart_stb, vram_stb, wram_stb};
        log_addr = cart_stb ? cart_addr : (vram_stb ? {2'b00, vram_addr} : {1'b0, wram_addr});
        log_we   = cart_stb ? cart_we : (vram_stb ? vram_we : wram_we);
        log_dat  = cart_stb ? cart_dat_o : (vram_stb ? vram_dat_o : wram_dat_o);
        cnt = stall_cfg;
        if (cnt > 0) begin
          t_stall = 1'b1;
          tst = T_STALL;
        end else begin
          t_stall = 1'b0;
          if (ack_same) t_ack = 1'b1;
          else tst = T_ACK;
        end
      end
      T_STALL: if (!any_cyc) begin
        t_stall = 1'b0;
        tst = T_IDLE;
      end else begin
        if (!any_stb) hold_viol = 1'b1;
        cnt--;
        if (cnt == 0) begin
          t_stall = 1'b0;
          if (ack_same) begin
            t_ack = 1'b1;
            tst = T_IDLE;
          end else tst = T_ACK;
        end
      end
      default: begin
        if (any_cyc) t_ack = 1'b1;
        tst = T_IDLE;
      end
    endcase
  end

  // Scoreboard
  typedef struct {
    logic       chk;
    logic [7:0] dat;
    int         due;
  } exp_t;
  exp_t q[$];
  int   neg_cnt = 0;
  logic local_phase = 1'b0, local_viol = 1'b0;
  int   phase_acks = 0;

  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (local_phase && (s_stall || any_cyc)) local_viol = 1'b1;
    if (rst_n && s_ack) begin
      if (local_phase) phase_acks++;
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got s_ack=1 with dat 0x%0h, expected no ack", s_dat_o);
      end else begin
        e = q.pop_front();
        if (e.chk) check_eq("ack_data", 32'(s_dat_o), 32'(e.dat));
        if (e.due >= 0) check_eq("ack_latency", 32'(neg_cnt), 32'(e.due));
      end
    end
  end

  task automatic loc(input logic [15:0] a, input logic we, input logic [7:0] d, input logic [7:0] x);
    exp_t e;
    s_cyc = 1'b1; s_stb = 1'b1; s_addr = a; s_we = we; s_dat_i = d;
    e.chk = !we; e.dat = x; e.due = neg_cnt + 2;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic end_burst();
    s_stb = 1'b0; s_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fwd(input logic [15:0] a, input logic we, input logic [7:0] d, input logic [7:0] x,
                     input int stall_n, input logic same);
    exp_t e;
    logic got, stall_ok;
    stall_cfg = stall_n; ack_same = same; rdata = x; hold_viol = 1'b0;
    s_cyc = 1'b1; s_stb = 1'b1; s_addr = a; s_we = we; s_dat_i = d;
    e.chk = !we; e.dat = x; e.due = -1;
    q.push_back(e);
    @(posedge clk); #1;
    s_stb = 1'b0;
    got = 1'b0; stall_ok = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (s_ack) got = 1'b1;
      else if (!s_stall) stall_ok = 1'b0;
    end
    check_eq("fwd_ack_seen", 32'(got), 32'd1);
    check_eq("fwd_stall_until_resp", 32'(stall_ok), 32'd1);
    @(posedge clk); #1;
    s_cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_dat_o", 32'(s_dat_o), 32'hFF);
    check_eq("rst_ack", 32'(s_ack), 32'd0);
    check_eq("rst_stall", 32'(s_stall), 32'd0);
    check_eq("rst_cyc_stb", 32'({any_cyc, any_stb}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // bank registers
    loc(16'hFF4F, 1'b1, 8'h00, 8'h00);
    loc(16'hFF70, 1'b1, 8'h00, 8'h00);
    loc(16'hFF4F, 1'b0, 8'h00, 8'hFE);
    loc(16'hFF70, 1'b0, 8'h00, 8'hF8);
    end_burst();

    // HRAM back-to-back
    local_phase = 1'b1;
    for (int i = 0; i < 128; i++) loc(16'hFF80 + 16'(i), 1'b1, 8'(i), 8'h00);
    for (int i = 0; i < 128; i++) loc(16'hFF80 + 16'(i), 1'b0, 8'h00, 8'(i));
    end_burst();
    local_phase = 1'b0;
    check_eq("hram_no_stall_no_target", 32'(local_viol), 32'd0);
    check_eq("hram_ack_count", 32'(phase_acks), 32'd256);

    // cart read with 7-cycle stall
    fwd(16'h1000, 1'b0, 8'h00, 8'hFF, 7, 1'b0);
    check_eq("cart_addr", 32'(log_addr), 32'h1000);
    check_eq("cart_sel", 32'(log_sel), 32'b100);
    check_eq("cart_stb_held", 32'(hold_viol), 32'd0);
    loc(16'hFF85, 1'b0, 8'h00, 8'h05);
    end_burst();

    // WRAM banking; register write directly followed by the translated access
    loc(16'hFF70, 1'b1, 8'h00, 8'h00);
    fwd(16'hD123, 1'b0, 8'h00, 8'h3C, 0, 1'b0);
    check_eq("wram_svbk0", 32'(log_addr), 32'h1123);
    check_eq("wram_sel", 32'(log_sel), 32'b001);
    loc(16'hFF70, 1'b1, 8'h05, 8'h00);
    fwd(16'hD123, 1'b0, 8'h00, 8'h5A, 0, 1'b1);
    check_eq("wram_svbk5", 32'(log_addr), 32'h5123);
    fwd(16'hE123, 1'b0, 8'h00, 8'h11, 1, 1'b1);
    check_eq("wram_echo_low", 32'(log_addr), 32'h0123);
    fwd(16'hF123, 1'b0, 8'h00, 8'h22, 0, 1'b0);
    check_eq("wram_echo_bank", 32'(log_addr), 32'h5123);

    // VRAM bank 1 write
    loc(16'hFF4F, 1'b1, 8'h01, 8'h00);
    fwd(16'h8000, 1'b1, 8'hAA, 8'h00, 2, 1'b0);
    check_eq("vram_addr", 32'(log_addr), 32'h2000);
    check_eq("vram_sel", 32'(log_sel), 32'b010);
    check_eq("vram_we", 32'(log_we), 32'd1);
    check_eq("vram_dat", 32'(log_dat), 32'hAA);
    loc(16'hFF4F, 1'b0, 8'h00, 8'hFF);
    loc(16'hFE10, 1'b0, 8'h00, 8'hFF);
    end_burst();

    // abort while cart stalls
    stall_cfg = 50; ack_same = 1'b0;
    s_cyc = 1'b1; s_stb = 1'b1; s_addr = 16'h0200; s_we = 1'b0;
    @(posedge clk); #1;
    s_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("abort_pre_cyc", 32'(cart_cyc), 32'd1);
    @(posedge clk); #1;
    s_cyc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_cyc_stb", 32'({cart_cyc, cart_stb}), 32'd0);
    check_eq("abort_stall", 32'(s_stall), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    loc(16'hFF90, 1'b0, 8'h00, 8'h10);
    end_burst();

    // reset in the middle of a forwarded transaction
    stall_cfg = 50;
    s_cyc = 1'b1; s_stb = 1'b1; s_addr = 16'h3000; s_we = 1'b0;
    @(posedge clk); #1;
    s_stb = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_cyc_stb", 32'({any_cyc, any_stb}), 32'd0);
    check_eq("midrst_stall_ack", 32'({s_stall, s_ack}), 32'd0);
    check_eq("midrst_dat_o", 32'(s_dat_o), 32'hFF);
    s_cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    loc(16'hFF4F, 1'b0, 8'h00, 8'hFE);
    loc(16'hFF70, 1'b0, 8'h00, 8'hF8);
    loc(16'hFF90, 1'b0, 8'h00, 8'h10);
    end_burst();
    repeat (2) @(posedge clk);

    check_eq("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gbc_memory_bus.md
Name: gbc_memory_bus

Overview:
- Game Boy Color CPU-side memory bus decoder.
- Accepts 8-bit pipelined Wishbone transactions from the CPU on one target port.
- Serves HRAM and the VBK/SVBK bank registers locally.
- Forwards all other in-range accesses, with bank translation, to three initiator ports: work RAM (32 KiB), video RAM (16 KiB) and cartridge (64 KiB space).

Parameters:
- HRAM_BASE, 16'hFF80, first byte of local HRAM; HRAM spans HRAM_BASE..16'hFFFF (128 bytes, IE at FFFF stored as HRAM).

Ports:
- CLK  in  1  system clock; all ports synchronous to it.
- RST  in  1  asynchronous, active-low reset.
- s_cyc, s_stb, s_we  in  1 each  CPU Wishbone cycle/strobe/write-enable.
- s_addr  in  16  CPU address.
- s_dat_i  in  8  CPU write data.
- s_dat_o  out  8  read data to CPU.
- s_ack, s_stall  out  1 each  Wishbone ack/stall to CPU.
- wram_cyc, wram_stb, wram_we  out  1 each; wram_addr  out  15; wram_dat_o  out  8; wram_dat_i  in  8; wram_ack, wram_stall  in  1 each.
- vram_*  same as wram_* but vram_addr is 14 bits.
- cart_*  same as wram_* but cart_addr is 16 bits.

Behaviour:
- Reset (RST=0, async):
  - All outputs 0 except s_dat_o=8'hFF.
  - VBK=0, SVBK=0, FSM to IDLE.
  - HRAM contents are not cleared.
- Acceptance: a request is accepted when s_cyc & s_stb & !s_stall; one transaction is outstanding at a time.
- Address map:
  - 0000-7FFF and A000-BFFF: cart, cart_addr = s_addr.
  - 8000-9FFF: vram, vram_addr = {VBK[0], s_addr[12:0]}.
  - C000-CFFF and E000-EFFF: wram, wram_addr = {3'b000, s_addr[11:0]}.
  - D000-DFFF and F000-FDFF: wram, wram_addr = {bank, s_addr[11:0]}, where bank = (SVBK[2:0]==0) ? 3'b001 : SVBK[2:0].
  - FF4F: VBK register, local. Write stores bit0; read returns {7'h7F, VBK}.
  - FF70: SVBK register, local. Write stores bits[2:0]; read returns {5'h1F, SVBK}.
  - FF80-FFFF: HRAM, local, byte read/write.
  - FE00-FF7F other than FF4F/FF70: local. Reads return 8'hFF, writes ignored.
- Local access:
  - s_ack high exactly the cycle after acceptance, for one cycle; s_dat_o valid in that cycle.
  - s_stall stays low, so back-to-back local accesses run at one per clock.
  - Register and HRAM writes take effect at the acceptance edge.
  - A bank-register write affects the translation of the very next accepted access.
- Forwarded access FSM, IDLE -> REQ -> WAIT -> RESP -> IDLE:
  - Acceptance latches the translated address, s_dat_i, s_we and target select; s_stall goes high the next cycle.
  - REQ: drive target cyc=1 and stb=1 with the latched addr/we/data; hold until target stall=0, then go to WAIT with stb=0 and cyc still 1.
  - WAIT: on target ack, capture target dat_i, drop cyc, go to RESP. No timeout; indefinite target stall/ack delay is tolerated.
  - RESP: s_ack=1 and s_dat_o=captured data for one cycle; s_stall low; a new request may be accepted in this same cycle.
  - Non-selected targets keep cyc and stb at 0 throughout.
  - Target ack arriving in the same cycle stb is accepted is valid: go straight to RESP.
- Abort: s_cyc falling while not IDLE drops target cyc/stb, returns to IDLE, produces no s_ack, and discards any late target ack.
- Stalls: s_stall is high in REQ and WAIT, low otherwise. It is never asserted during reset.
- Width: s_dat_o holds its last value while s_ack is low; data is 8 bits, addresses are truncated exactly as above.

Test Plan:
- Reset, write FF4F<=0 and FF70<=0, then read back -> FF4F reads 8'hFE, FF70 reads 8'hF8, each acked one cycle after acceptance.
- Write FF80+i <= i for i=0..127 back-to-back, then read all -> one ack per clock with stall never high; FFFF reads 8'h7F; no wram/vram/cart cyc ever asserted.
- Read 0x1000 with cart stalling 7 cycles then acking 8'hFF -> cart_addr=16'h1000, cart_stb held through the stall, s_stall high until RESP, then one s_ack with s_dat_o=8'hFF; next HRAM access proceeds normally.
- SVBK=0 then 5; read D123 each time -> wram_addr=15'h1123 then 15'h5123. Read E123 -> wram_addr=15'h0123.
- VBK=1; write 8000<=8'hAA -> vram_addr=14'h2000, vram_we=1, vram_dat_o=8'hAA.
- Drop s_cyc while cart is stalled -> cart_cyc falls next cycle, no s_ack, bus accepts the next request; RST asserted mid-transaction -> all strobes low immediately.
